// File: rtl/track_pkg.sv
// Shared types and default constants for the frame-synchronous mark-out tracking controller.
package track_pkg;

    localparam int unsigned COORD_W = 12;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned WD_W    = 24;

    localparam logic [COORD_W-1:0] AMIN_DEF   = 12'd64;
    localparam int unsigned        N_ACQ_DEF  = 3;
    localparam int unsigned        N_LOSE_DEF = 5;
    localparam logic [WD_W-1:0]    WD_CYC_DEF = 24'd2_000_000;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_LOCKED = 2'd1,
        ST_COAST  = 2'd2,
        ST_FAULT  = 2'd3
    } trk_state_e;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } coord_t;

    // Hysteresis counters stick at all-ones rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/frame_edge_det.sv
// Registers vsync once and flags the cycle on which it enters its active level.
module frame_edge_det #(
    parameter logic VS_POL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic vs,
    output logic bnd_c
);

    logic vs_d;
    logic vs_q;

    always_comb begin
        vs_d = vs;
    end

    // Reset to the active level so a vsync already active at release is not a boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q <= VS_POL;
        end else begin
            vs_q <= vs_d;
        end
    end

    assign bnd_c = (vs_q != VS_POL) && (vs == VS_POL);

endmodule

// File: rtl/track_mark_ctrl.sv
// Per-frame acquire/lose hysteresis, frame-aligned overlay select, result handshake and vsync watchdog.
module track_mark_ctrl
    import track_pkg::*;
#(
    parameter logic [COORD_W-1:0] AMIN   = AMIN_DEF,
    parameter int unsigned        N_ACQ  = N_ACQ_DEF,
    parameter int unsigned        N_LOSE = N_LOSE_DEF,
    parameter logic               VS_POL = 1'b1,
    parameter logic [WD_W-1:0]    WD_CYC = WD_CYC_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vs,
    input  logic [COORD_W-1:0] px,
    input  logic [COORD_W-1:0] py,
    input  logic [COORD_W-1:0] a,
    input  logic               user_en,
    output logic               mark_out_en,
    output logic [COORD_W-1:0] tgt_x,
    output logic [COORD_W-1:0] tgt_y,
    output logic               tgt_valid,
    output logic               frm_stb,
    input  logic               frm_ack,
    output logic               frm_ovf,
    output logic               wd_fault,
    output logic [1:0]         state_o
);

    logic bnd_c;

    frame_edge_det #(
        .VS_POL (VS_POL)
    ) u_edge (
        .clk   (clk),
        .rst   (rst),
        .vs    (vs),
        .bnd_c (bnd_c)
    );

    trk_state_e       state_q, state_d;
    logic [CNT_W-1:0] acq_q, acq_d;
    logic [CNT_W-1:0] lose_q, lose_d;
    coord_t           tgt_q, tgt_d;
    logic             tgt_valid_q, tgt_valid_d;
    logic             mark_q, mark_d;
    logic             stb_q, stb_d;
    logic             pend_q, pend_d;
    logic             ovf_q, ovf_d;
    logic             wd_fault_q, wd_fault_d;
    logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;

    logic             hit_c;
    logic             wd_exp_c;
    logic [CNT_W-1:0] acq_inc_c;
    logic [CNT_W-1:0] lose_inc_c;

    always_comb begin
        state_d    = state_q;
        acq_d      = acq_q;
        lose_d     = lose_q;
        tgt_d      = tgt_q;
        mark_d     = mark_q;
        stb_d      = 1'b0;
        wd_fault_d = wd_fault_q;
        wd_cnt_d   = wd_cnt_q;
        hit_c      = (a >= AMIN);
        acq_inc_c  = sat_inc(acq_q);
        lose_inc_c = sat_inc(lose_q);
        wd_exp_c   = !bnd_c && (wd_cnt_q == WD_CYC - WD_W'(1));

        if (bnd_c) begin
            wd_cnt_d = '0;
        end else if (wd_cnt_q != WD_CYC) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end

        // Watchdog expiry is the only path that switches the overlay mid-frame.
        if (wd_exp_c) begin
            state_d    = ST_FAULT;
            wd_fault_d = 1'b1;
            mark_d     = 1'b0;
            acq_d      = '0;
            lose_d     = '0;
        end else if (bnd_c) begin
            case (state_q)
                ST_SEARCH: begin
                    if (!hit_c) begin
                        acq_d = '0;
                    end else if (acq_inc_c == CNT_W'(N_ACQ)) begin
                        state_d = ST_LOCKED;
                        acq_d   = '0;
                        tgt_d.x = px;
                        tgt_d.y = py;
                    end else begin
                        acq_d = acq_inc_c;
                    end
                end
                ST_LOCKED: begin
                    if (hit_c) begin
                        tgt_d.x = px;
                        tgt_d.y = py;
                        lose_d  = '0;
                    end else if (CNT_W'(1) >= CNT_W'(N_LOSE)) begin
                        state_d = ST_SEARCH;
                        acq_d   = '0;
                        lose_d  = '0;
                        tgt_d   = '0;
                    end else begin
                        state_d = ST_COAST;
                        lose_d  = CNT_W'(1);
                    end
                end
                ST_COAST: begin
                    if (hit_c) begin
                        state_d = ST_LOCKED;
                        tgt_d.x = px;
                        tgt_d.y = py;
                        lose_d  = '0;
                    end else if (lose_inc_c >= CNT_W'(N_LOSE)) begin
                        state_d = ST_SEARCH;
                        acq_d   = '0;
                        lose_d  = '0;
                        tgt_d   = '0;
                    end else begin
                        lose_d = lose_inc_c;
                    end
                end
                ST_FAULT: begin
                    // Recovery boundary: its sample is discarded and no result is posted.
                    state_d    = ST_SEARCH;
                    wd_fault_d = 1'b0;
                    acq_d      = '0;
                    lose_d     = '0;
                    tgt_d      = '0;
                end
            endcase
            stb_d  = (state_q != ST_FAULT);
            mark_d = user_en && ((state_d == ST_LOCKED) || (state_d == ST_COAST));
        end

        tgt_valid_d = (state_d == ST_LOCKED) || (state_d == ST_COAST);

        // A new strobe re-arms pending even if acked in the same cycle.
        pend_d = stb_q ? 1'b1 : (frm_ack ? 1'b0 : pend_q);
        ovf_d  = ovf_q || (stb_q && pend_q && !frm_ack);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_SEARCH;
            acq_q       <= '0;
            lose_q      <= '0;
            tgt_q       <= '0;
            tgt_valid_q <= 1'b0;
            mark_q      <= 1'b0;
            stb_q       <= 1'b0;
            pend_q      <= 1'b0;
            ovf_q       <= 1'b0;
            wd_fault_q  <= 1'b0;
            wd_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            acq_q       <= acq_d;
            lose_q      <= lose_d;
            tgt_q       <= tgt_d;
            tgt_valid_q <= tgt_valid_d;
            mark_q      <= mark_d;
            stb_q       <= stb_d;
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
            wd_fault_q  <= wd_fault_d;
            wd_cnt_q    <= wd_cnt_d;
        end
    end

    assign mark_out_en = mark_q;
    assign tgt_x       = tgt_q.x;
    assign tgt_y       = tgt_q.y;
    assign tgt_valid   = tgt_valid_q;
    assign frm_stb     = stb_q;
    assign frm_ovf     = ovf_q;
    assign wd_fault    = wd_fault_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_track_mark_ctrl.sv
// Directed bench for track_mark_ctrl: acquire, coast/lose, frame-aligned enable, watchdog, handshake, reset.
module tb_track_mark_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        vs;
    logic [11:0] px, py, a;
    logic        user_en;
    logic        mark_out_en;
    logic [11:0] tgt_x, tgt_y;
    logic        tgt_valid;
    logic        frm_stb;
    logic        frm_ack;
    logic        frm_ovf;
    logic        wd_fault;
    logic [1:0]  state_o;

    int n_cmp = 0;
    int n_err = 0;
    logic stb_seen;
    int wd_wait;

    track_mark_ctrl #(
        .AMIN   (12'd64),
        .N_ACQ  (3),
        .N_LOSE (5),
        .VS_POL (1'b1),
        .WD_CYC (24'd1000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .vs          (vs),
        .px          (px),
        .py          (py),
        .a           (a),
        .user_en     (user_en),
        .mark_out_en (mark_out_en),
        .tgt_x       (tgt_x),
        .tgt_y       (tgt_y),
        .tgt_valid   (tgt_valid),
        .frm_stb     (frm_stb),
        .frm_ack     (frm_ack),
        .frm_ovf     (frm_ovf),
        .wd_fault    (wd_fault),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One-cycle vsync pulse carrying the box results; captures frm_stb after the boundary.
    task automatic frame(input logic [11:0] ai, input logic [11:0] xi, input logic [11:0] yi);
        @(negedge clk);
        a  = ai;
        px = xi;
        py = yi;
        vs = 1'b1;
        @(negedge clk);
        stb_seen = frm_stb;
        vs = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"}, 32'(state_o), 32'd0);
        chk({tag, "_mark"}, 32'(mark_out_en), 32'd0);
        chk({tag, "_tx"}, 32'(tgt_x), 32'd0);
        chk({tag, "_ty"}, 32'(tgt_y), 32'd0);
        chk({tag, "_valid"}, 32'(tgt_valid), 32'd0);
        chk({tag, "_stb"}, 32'(frm_stb), 32'd0);
        chk({tag, "_ovf"}, 32'(frm_ovf), 32'd0);
        chk({tag, "_wd"}, 32'(wd_fault), 32'd0);
    endtask

    initial begin
        rst = 1'b1; vs = 1'b0; px = '0; py = '0; a = '0;
        user_en = 1'b1; frm_ack = 1'b1; stb_seen = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("reset");

        // Acquire over three hit frames
        frame(12'd100, 12'd320, 12'd240);
        chk("acq1_stb", 32'(stb_seen), 32'd1);
        chk("acq1_state", 32'(state_o), 32'd0);
        frame(12'd100, 12'd320, 12'd240);
        chk("acq2_state", 32'(state_o), 32'd0);
        chk("acq2_valid", 32'(tgt_valid), 32'd0);
        frame(12'd100, 12'd320, 12'd240);
        chk("acq3_state", 32'(state_o), 32'd1);
        chk("acq3_tx", 32'(tgt_x), 32'd320);
        chk("acq3_ty", 32'(tgt_y), 32'd240);
        chk("acq3_valid", 32'(tgt_valid), 32'd1);
        chk("acq3_mark", 32'(mark_out_en), 32'd1);

        // Coast with held target, then reacquire
        frame(12'd0, 12'd1, 12'd2);
        chk("coast1_state", 32'(state_o), 32'd2);
        chk("coast1_tx", 32'(tgt_x), 32'd320);
        chk("coast1_ty", 32'(tgt_y), 32'd240);
        chk("coast1_valid", 32'(tgt_valid), 32'd1);
        chk("coast1_mark", 32'(mark_out_en), 32'd1);
        repeat (3) frame(12'd0, 12'd1, 12'd2);
        chk("coast4_state", 32'(state_o), 32'd2);
        chk("coast4_tx", 32'(tgt_x), 32'd320);
        frame(12'd200, 12'd10, 12'd20);
        chk("relock_state", 32'(state_o), 32'd1);
        chk("relock_tx", 32'(tgt_x), 32'd10);
        chk("relock_ty", 32'(tgt_y), 32'd20);

        // Five misses return to SEARCH
        repeat (4) frame(12'd0, 12'd0, 12'd0);
        chk("lose4_state", 32'(state_o), 32'd2);
        frame(12'd0, 12'd0, 12'd0);
        chk("lose5_state", 32'(state_o), 32'd0);
        chk("lose5_tx", 32'(tgt_x), 32'd0);
        chk("lose5_ty", 32'(tgt_y), 32'd0);
        chk("lose5_valid", 32'(tgt_valid), 32'd0);
        chk("lose5_mark", 32'(mark_out_en), 32'd0);

        // Interrupted acquire
        frame(12'd100, 12'd50, 12'd60);
        frame(12'd100, 12'd50, 12'd60);
        frame(12'd10, 12'd50, 12'd60);
        chk("intr3_acq", 32'(dut.acq_q), 32'd0);
        chk("intr3_state", 32'(state_o), 32'd0);
        frame(12'd100, 12'd50, 12'd60);
        frame(12'd100, 12'd50, 12'd60);
        chk("intr5_state", 32'(state_o), 32'd0);
        frame(12'd100, 12'd50, 12'd60);
        chk("intr6_state", 32'(state_o), 32'd1);
        chk("intr6_tx", 32'(tgt_x), 32'd50);

        // Mid-frame user_en drop waits for the next boundary; AMIN boundary cases
        user_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("en_mid_mark", 32'(mark_out_en), 32'd1);
        frame(12'd64, 12'd5, 12'd6);
        chk("en_a64_state", 32'(state_o), 32'd1);
        chk("en_a64_mark", 32'(mark_out_en), 32'd0);
        chk("en_a64_tx", 32'(tgt_x), 32'd5);
        frame(12'd63, 12'd8, 12'd8);
        chk("en_a63_state", 32'(state_o), 32'd2);
        chk("en_a63_tx", 32'(tgt_x), 32'd5);
        user_en = 1'b1;
        frame(12'd64, 12'd7, 12'd9);
        chk("en_back_state", 32'(state_o), 32'd1);
        chk("en_back_mark", 32'(mark_out_en), 32'd1);

        // Watchdog: fault lands exactly 1000 cycles after the last boundary
        repeat (985) @(negedge clk);
        chk("wd_early", 32'(wd_fault), 32'd0);
        chk("wd_early_state", 32'(state_o), 32'd1);
        wd_wait = 0;
        while (!wd_fault && wd_wait < 40) begin
            @(negedge clk);
            wd_wait++;
        end
        chk("wd_latency", 32'(wd_wait), 32'd12);
        chk("wd_fault", 32'(wd_fault), 32'd1);
        chk("wd_state", 32'(state_o), 32'd3);
        chk("wd_mark", 32'(mark_out_en), 32'd0);
        chk("wd_valid", 32'(tgt_valid), 32'd0);
        frame(12'd100, 12'd1, 12'd1);
        chk("wdrec_stb", 32'(stb_seen), 32'd0);
        chk("wdrec_state", 32'(state_o), 32'd0);
        chk("wdrec_fault", 32'(wd_fault), 32'd0);
        frame(12'd100, 12'd1, 12'd1);
        chk("wdnext_stb", 32'(stb_seen), 32'd1);
        chk("wdnext_state", 32'(state_o), 32'd0);

        // Handshake overflow, then mid-frame reset
        frame(12'd0, 12'd0, 12'd0);
        frm_ack = 1'b0;
        frame(12'd100, 12'd11, 12'd22);
        chk("hs1_ovf", 32'(frm_ovf), 32'd0);
        frame(12'd100, 12'd11, 12'd22);
        chk("hs2_ovf", 32'(frm_ovf), 32'd1);
        frame(12'd100, 12'd11, 12'd22);
        chk("hs3_state", 32'(state_o), 32'd1);
        chk("hs3_tx", 32'(tgt_x), 32'd11);
        chk("hs3_ovf", 32'(frm_ovf), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        frm_ack = 1'b1;
        chk_all_zero("midrst");
        frame(12'd100, 12'd3, 12'd4);
        chk("postrst_stb", 32'(stb_seen), 32'd1);
        chk("postrst_state", 32'(state_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
